mdu_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer sitting beside the execute-stage `alu`. Decode routes OP instructions with funct7 = 0000001 here instead of to the ALU. The block accepts one operation, runs a fixed-length shift-add or restoring-divide sequence over a shared 32-bit adder, and returns the result with a one-cycle done pulse. It holds the pipeline stalled through `busy_o` while it works.

---
 rtl/mdu_seq_if.sv | 25 ++
 rtl/mdu_seq.sv | 157 +++++++++++++++
 tb/tb_mdu_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the mdu_seq sequencer.
// The master side issues operations and watches the handshake; the slave side is the sequencer.
interface mdu_seq_if #(
    parameter int DWIDTH = 32
);
    logic              start_i;
    logic [2:0]        funct3_i;
    logic [DWIDTH-1:0] rs1_i;
    logic [DWIDTH-1:0] rs2_i;
    logic              flush_i;
    logic              ready_o;
    logic              busy_o;
    logic              done_o;
    logic [DWIDTH-1:0] res_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  ready_o, busy_o, done_o, res_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output ready_o, busy_o, done_o, res_o
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// sharing one DWIDTH+1 bit adder, one iteration per clock.
module mdu_seq #(
    parameter int DWIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_seq_if.slave   bus
);
    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [DWIDTH-1:0]   op1_q;   // multiplicand / dividend
    logic [DWIDTH-1:0]   op2_q;   // multiplier / divisor
    logic [2*DWIDTH-1:0] acc_q;   // product, or {remainder, quotient}
    logic [DWIDTH-1:0]   res_q;
    logic                sign_a_q, sign_b_q;
    logic [CW-1:0]       cnt_q;

    // Request decode, only meaningful in IDLE
    logic              accept, in_div, div_zero, div_ovf, special;
    logic [DWIDTH-1:0] special_res;

    assign accept   = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
    assign in_div   = bus.funct3_i[2];
    assign div_zero = in_div && (bus.rs2_i == '0);
    assign div_ovf  = in_div && !bus.funct3_i[0] && (bus.rs1_i == MIN_NEG) && (bus.rs2_i == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else if (!bus.funct3_i[1])
            special_res = MIN_NEG;
    end

    // Operand signedness for the latched operation
    logic is_div, a_signed, b_signed, neg_a, neg_b;

    assign is_div   = op_q[2];
    assign a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    assign b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    assign neg_a    = a_signed && op1_q[DWIDTH-1];
    assign neg_b    = b_signed && op2_q[DWIDTH-1];

    // Shared adder: add multiplicand into the product high half, or trial-subtract the divisor
    logic [DWIDTH-1:0] acc_hi, acc_lo;
    logic [DWIDTH:0]   add_a, add_b, sum, mul_hi;
    logic [DWIDTH-1:0] rem_next;

    assign acc_hi   = acc_q[2*DWIDTH-1:DWIDTH];
    assign acc_lo   = acc_q[DWIDTH-1:0];
    assign add_a    = is_div ? {acc_hi, op1_q[DWIDTH-1]} : {1'b0, acc_hi};
    assign add_b    = is_div ? ~{1'b0, op2_q} : {1'b0, op1_q};
    assign sum      = add_a + add_b + (DWIDTH+1)'(is_div);
    assign mul_hi   = op2_q[0] ? sum : {1'b0, acc_hi};
    assign rem_next = sum[DWIDTH] ? {acc_hi[DWIDTH-2:0], op1_q[DWIDTH-1]} : sum[DWIDTH-1:0];

    // Sign correction and result selection
    logic [2*DWIDTH-1:0] prod_fix;
    logic [DWIDTH-1:0]   quot_fix, rem_fix, fix_res;

    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a_q ? -acc_hi : acc_hi;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fix_res = rem_fix;
        case (op_q)
            3'b000:                 fix_res = prod_fix[DWIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*DWIDTH-1:DWIDTH];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start_i) state_d = special ? S_DONE : S_PREP;
                S_PREP:  state_d = S_CALC;
                S_CALC:  if (cnt_q == CW'(DWIDTH-1)) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Internal registers may change under a flush; only res_o must be protected, and FIX still writes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.funct3_i;
                        op1_q <= bus.rs1_i;
                        op2_q <= bus.rs2_i;
                        if (special)
                            res_q <= special_res;
                    end
                end
                S_PREP: begin
                    sign_a_q <= neg_a;
                    sign_b_q <= neg_b;
                    op1_q    <= neg_a ? -op1_q : op1_q;
                    op2_q    <= neg_b ? -op2_q : op2_q;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                S_CALC: begin
                    if (is_div) begin
                        acc_q <= {rem_next, acc_lo[DWIDTH-2:0], ~sum[DWIDTH]};
                        op1_q <= op1_q << 1;
                    end else begin
                        acc_q <= {mul_hi, acc_lo[DWIDTH-1:1]};
                        op2_q <= op2_q >> 1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX:   res_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.res_o   = res_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: drivers queue expected results, a negedge monitor
// pops and compares on every done pulse.
module tb_mdu_seq;
    localparam int W = 32;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mdu_seq_if #(.DWIDTH(W)) bus ();

    mdu_seq #(.DWIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_done = 0;
    int          n_exp_done = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_done: got done_o=1 with res 0x%08h, expected no done", bus.res_o);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, bus.res_o, mon_e.val);
                last_res = mon_e.val;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) begin
            n_checks++;
            $display("FAIL ready_timeout: ready_o=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.start_i  = 1'b1;
    endtask

    // Issue one operation, queue its result, and count the cycles busy_o stays high
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
        int n = 0;
        wait_ready();
        drive_req(f3, a, b);
        exp_q.push_back('{name, exp});
        n_exp_done++;
        @(negedge clk);
        bus.start_i = 1'b0;
        while (bus.busy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_busy",  32'(bus.busy_o),  32'd0);
        check("rst_done",  32'(bus.done_o),  32'd0);
        check("rst_res",   bus.res_o,        32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal operations: 35 busy cycles each
        issue("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        issue("mul_shift",     3'b000, 32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 35);
        issue("mulh_min_min",  3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
        issue("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 35);
        issue("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        issue("mulhu_max_max", 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        issue("div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
        issue("rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
        issue("divu_100_7",    3'b101, 32'd100,        32'd7,         32'd14,        35);
        issue("remu_100_7",    3'b111, 32'd100,        32'd7,         32'd2,         35);
        issue("div_20_m3",     3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 35);
        issue("rem_20_m3",     3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         35);

        // Special cases: one busy cycle
        issue("divu_7_0",      3'b101, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        issue("rem_7_0",       3'b110, 32'd7,          32'd0,         32'd7,         1);
        issue("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Flush at CALC iteration 10: no result, res_o held
        wait_ready();
        drive_req(3'b101, 32'd1000, 32'd3);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (11) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready", 32'(bus.ready_o), 32'd1);
        check("flush_done",  32'(bus.done_o),  32'd0);
        check("flush_res",   bus.res_o,        last_res);
        repeat (40) @(negedge clk);
        issue("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 35);

        // Reset in the middle of CALC
        wait_ready();
        drive_req(3'b000, 32'd5, 32'd6);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready_o), 32'd1);
        check("midrst_busy",  32'(bus.busy_o),  32'd0);
        check("midrst_done",  32'(bus.done_o),  32'd0);
        check("midrst_res",   bus.res_o,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // start_i held high through the whole operation: exactly one result
        begin
            int n = 0;
            wait_ready();
            drive_req(3'b101, 32'd9, 32'd3);
            exp_q.push_back('{"held_start_divu", 32'd3});
            n_exp_done++;
            @(negedge clk);
            while (!bus.done_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            bus.start_i = 1'b0;
            repeat (50) @(negedge clk);
        end

        check("done_count",    32'(n_done),       32'(n_exp_done));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
